// File: rtl/instr_issuer_pkg.sv
// rtl/instr_issuer_pkg.sv - shared types, width defaults and helpers for instr_issuer
package instr_issuer_pkg;

  localparam int IW_DEFAULT = 16;
  localparam int DW_DEFAULT = 8;
  localparam int RC_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  function automatic logic [RC_W-1:0] sat_inc(input logic [RC_W-1:0] v);
    return (v == {RC_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/instr_issuer_if.sv
// rtl/instr_issuer_if.sv - load, cpu issue and status signals of instr_issuer
interface instr_issuer_if
  import instr_issuer_pkg::*;
#(
  parameter int IW = IW_DEFAULT,
  parameter int DW = DW_DEFAULT
);
  logic            LoadValid;
  logic [IW-1:0]   LoadInstr;
  logic            LoadReady;
  logic            Start;
  logic [IW-1:0]   Instruction;
  logic            InstrValid;
  logic            CPUReady;
  logic [DW-1:0]   ALUResult;
  logic [DW-1:0]   LastResult;
  logic [RC_W-1:0] ResultCount;
  logic            Busy;
  logic            Done;
  logic [DW-1:0]   Checksum;

  modport slave (
    input  LoadValid, LoadInstr, Start, CPUReady, ALUResult,
    output LoadReady, Instruction, InstrValid, LastResult, ResultCount, Busy, Done, Checksum
  );

  modport master (
    output LoadValid, LoadInstr, Start, CPUReady, ALUResult,
    input  LoadReady, Instruction, InstrValid, LastResult, ResultCount, Busy, Done, Checksum
  );
endinterface

// File: rtl/issue_fifo.sv
// rtl/issue_fifo.sv - synchronous program buffer; head is combinational from the read pointer
module issue_fifo #(
  parameter int DEPTH = 8,
  parameter int IW    = 16
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic [IW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [IW-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] mem_q [DEPTH];
  logic          push_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instr_issuer.sv
// rtl/instr_issuer.sv - issues buffered instructions to a cpu and captures its results
// Optional running XOR of results enabled by INSTR_ISSUER_CHECKSUM_EN.
module instr_issuer
  import instr_issuer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IW    = IW_DEFAULT,
  parameter int DW    = DW_DEFAULT
) (
  input logic           CLK,
  input logic           RESET,
  instr_issuer_if.slave bus
);
  state_t          state_q, state_d;
  logic [DW-1:0]   last_q, last_d;
  logic [RC_W-1:0] rcount_q, rcount_d;
  logic            fifo_full, fifo_empty, fifo_pop, instr_valid;
  logic [IW-1:0]   fifo_head;

  issue_fifo #(.DEPTH(DEPTH), .IW(IW)) u_fifo (
    .clk       (CLK),
    .resetn    (RESET),
    .push      (bus.LoadValid),
    .push_data (bus.LoadInstr),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    rcount_d    = rcount_q;
    fifo_pop    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          rcount_d = '0;
          state_d  = fifo_empty ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        instr_valid = 1'b1;
        if (bus.CPUReady) begin
          fifo_pop = 1'b1;
          state_d  = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        last_d   = bus.ALUResult;
        rcount_d = sat_inc(rcount_q);
        // Occupancy is registered, so a push this cycle does not keep us out of DONE.
        state_d  = fifo_empty ? ST_DONE : ST_RUN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= ST_IDLE;
      last_q   <= '0;
      rcount_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      rcount_q <= rcount_d;
    end
  end

`ifdef INSTR_ISSUER_CHECKSUM_EN
  logic [DW-1:0] cks_q, cks_d;

  always_comb begin
    cks_d = cks_q;
    if (state_q == ST_IDLE && bus.Start) cks_d = '0;
    else if (state_q == ST_CAPTURE)      cks_d = cks_q ^ bus.ALUResult;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) cks_q <= '0;
    else        cks_q <= cks_d;
  end

  assign bus.Checksum = cks_q;
`else
  assign bus.Checksum = '0;
`endif

  assign bus.LoadReady   = !fifo_full;
  assign bus.InstrValid  = instr_valid;
  assign bus.Instruction = instr_valid ? fifo_head : '0;
  assign bus.LastResult  = last_q;
  assign bus.ResultCount = rcount_q;
  assign bus.Busy        = (state_q == ST_RUN) || (state_q == ST_CAPTURE);
  assign bus.Done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_issuer.sv
// tb/tb_instr_issuer.sv - scoreboard bench for instr_issuer
module tb_instr_issuer;

  typedef struct {
    logic [7:0] last;
    logic [7:0] cnt;
    logic [7:0] cks;
  } done_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  instr_issuer_if #(.IW(16), .DW(8)) bus ();

  instr_issuer #(.DEPTH(8), .IW(16), .DW(8)) dut (
    .CLK   (clk),
    .RESET (resetn),
    .bus   (bus)
  );

  logic [15:0] exp_instr_q[$];
  logic [7:0]  alu_q[$];
  done_t       exp_done_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  int done_count = 0;
  int iv_seen = 0;

  function automatic logic [7:0] exp_cks(input logic [7:0] x);
`ifdef INSTR_ISSUER_CHECKSUM_EN
    return x;
`else
    return 8'h00 & x;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: scores issues and Done pulses, and plays the cpu's result for each issue.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.InstrValid === 1'b1) iv_seen++;
      if (bus.InstrValid === 1'b1 && bus.CPUReady === 1'b1) begin
        if (exp_instr_q.size() == 0) chk("unexpected_issue", 32'(bus.Instruction), 32'hFFFF_FFFF);
        else chk("issue_instr", 32'(bus.Instruction), 32'(exp_instr_q.pop_front()));
        bus.ALUResult = (alu_q.size() != 0) ? alu_q.pop_front() : 8'h00;
      end
      if (bus.Done === 1'b1) begin
        done_t e;
        done_count++;
        if (exp_done_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          e = exp_done_q.pop_front();
          chk("done_last_result", 32'(bus.LastResult), 32'(e.last));
          chk("done_result_count", 32'(bus.ResultCount), 32'(e.cnt));
          chk("done_checksum", 32'(bus.Checksum), 32'(e.cks));
        end
      end
    end
  end

  task automatic push(input logic [15:0] v);
    int n;
    n = 0;
    while (bus.LoadReady !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("push_timeout", 32'd0, 32'd1);
    bus.LoadValid = 1'b1;
    bus.LoadInstr = v;
    exp_instr_q.push_back(v);
    @(posedge clk); #1;
    bus.LoadValid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.Start = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int bound);
    for (int i = 0; i < bound && done_count == d0; i++) @(posedge clk);
    if (done_count == d0) chk("done_timeout", 32'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", 32'(done_count - d0), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_instr_valid"}, 32'(bus.InstrValid), 32'd0);
    chk({tag, "_instruction"}, 32'(bus.Instruction), 32'd0);
    chk({tag, "_busy"}, 32'(bus.Busy), 32'd0);
    chk({tag, "_load_ready"}, 32'(bus.LoadReady), 32'd1);
    chk({tag, "_last_result"}, 32'(bus.LastResult), 32'd0);
    chk({tag, "_result_count"}, 32'(bus.ResultCount), 32'd0);
    chk({tag, "_done"}, 32'(bus.Done), 32'd0);
    chk({tag, "_checksum"}, 32'(bus.Checksum), 32'd0);
  endtask

  initial begin
    int d0;
    logic [7:0] x;
    bus.LoadValid = 1'b0;
    bus.LoadInstr = '0;
    bus.Start     = 1'b0;
    bus.CPUReady  = 1'b0;
    bus.ALUResult = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    resetn = 1'b1;

    // Two-instruction program
    bus.CPUReady = 1'b1;
    push(16'h1234);
    push(16'h5678);
    alu_q.push_back(8'h0A);
    alu_q.push_back(8'h0B);
    exp_done_q.push_back('{8'h0B, 8'd2, exp_cks(8'h0B ^ 8'h0A)});
    d0 = done_count;
    pulse_start();
    wait_done(d0, 40);

    // Fill to full, one issue frees a slot, then wrap with 12 pushes total
    bus.CPUReady = 1'b0;
    for (int i = 0; i < 8; i++) push(16'h0100 + 16'(i));
    chk("full_load_ready", 32'(bus.LoadReady), 32'd0);
    x = 8'h00;
    for (int i = 0; i < 12; i++) begin
      alu_q.push_back(8'h20 + 8'(i));
      x = x ^ (8'h20 + 8'(i));
    end
    exp_done_q.push_back('{8'h2B, 8'd12, exp_cks(x)});
    d0 = done_count;
    pulse_start();
    bus.CPUReady = 1'b1;
    @(posedge clk); #1;
    bus.CPUReady = 1'b0;
    chk("after_pop_load_ready", 32'(bus.LoadReady), 32'd1);
    bus.CPUReady = 1'b1;
    for (int i = 8; i < 12; i++) push(16'h0100 + 16'(i));
    wait_done(d0, 80);

    // Start with an empty buffer
    iv_seen = 0;
    exp_done_q.push_back('{8'h2B, 8'd0, 8'h00});
    d0 = done_count;
    pulse_start();
    wait_done(d0, 2);
    chk("empty_no_instr_valid", 32'(iv_seen), 32'd0);

    // CPU stalled in RUN
    bus.CPUReady = 1'b0;
    push(16'hBEEF);
    d0 = done_count;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_instruction", 32'(bus.Instruction), 32'hBEEF);
      chk("stall_instr_valid", 32'(bus.InstrValid), 32'd1);
      chk("stall_result_count", 32'(bus.ResultCount), 32'd0);
    end
    @(posedge clk); #1;
    chk("stall_load_ready", 32'(bus.LoadReady), 32'd1);
    alu_q.push_back(8'h55);
    exp_done_q.push_back('{8'h55, 8'd1, exp_cks(8'h55)});
    bus.CPUReady = 1'b1;
    wait_done(d0, 20);

    // Reset mid-RUN with three entries queued
    bus.CPUReady = 1'b0;
    push(16'hA001);
    push(16'hA002);
    push(16'hA003);
    pulse_start();
    @(posedge clk); #1;
    chk("pre_reset_busy", 32'(bus.Busy), 32'd1);
    resetn = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midrun_reset");
    resetn = 1'b1;
    exp_instr_q.delete();
    iv_seen = 0;
    exp_done_q.push_back('{8'h00, 8'd0, 8'h00});
    d0 = done_count;
    pulse_start();
    wait_done(d0, 2);
    chk("reset_discard_no_issue", 32'(iv_seen), 32'd0);

    // Checksum cancels out
    bus.CPUReady = 1'b1;
    push(16'h00F0);
    push(16'h000F);
    push(16'h00FF);
    alu_q.push_back(8'hF0);
    alu_q.push_back(8'h0F);
    alu_q.push_back(8'hFF);
    exp_done_q.push_back('{8'hFF, 8'd3, 8'h00});
    d0 = done_count;
    pulse_start();
    wait_done(d0, 40);

    chk("leftover_expected_issues", 32'(exp_instr_q.size()), 32'd0);
    chk("leftover_expected_done", 32'(exp_done_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instr_issuer.md
INSTR_ISSUER -- requirements
Module: instr_issuer

Interface
REQ-001 Parameter DEPTH, default 8, program-buffer entries (power of 2, 2..16).
REQ-002 Parameter IW, default 16, instruction width.
REQ-003 Parameter DW, default 8, ALU result width.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RESET  input  1  synchronous, active-low reset (asserted when 0).
REQ-006 LoadValid  input  1  load-side instruction present.
REQ-007 LoadInstr  input  IW  instruction to append to buffer.
REQ-008 LoadReady  output  1  buffer not full; push occurs when LoadValid && LoadReady.
REQ-009 Start  input  1  begin issuing; honoured only in IDLE.
REQ-010 Instruction  output  IW  instruction driven to cpu.
REQ-011 InstrValid  output  1  Instruction valid.
REQ-012 CPUReady  input  1  cpu accepts; issue occurs when InstrValid && CPUReady.
REQ-013 ALUResult  input  DW  cpu result.
REQ-014 LastResult  output  DW  most recently captured ALUResult.
REQ-015 ResultCount  output  8  results captured since Start, saturating at 255.
REQ-016 Busy  output  1  high in RUN and CAPTURE.
REQ-017 Done  output  1  one-cycle pulse on program completion.
REQ-018 Checksum  output  DW  XOR of captured results (see Configuration).

Function
REQ-019 FSM states IDLE, RUN, CAPTURE, DONE; registered state.
REQ-020 IDLE: InstrValid=0, Instruction=0; Start=1 with buffer non-empty -> RUN; Start with empty buffer -> DONE.
REQ-021 RUN: InstrValid=1, Instruction = buffer head (combinational from head); on issue pop head -> CAPTURE.
REQ-022 CAPTURE: InstrValid=0; sample ALUResult into LastResult, increment ResultCount; buffer non-empty -> RUN, else -> DONE.
REQ-023 Issue-to-capture latency exactly 1 cycle; at most one issue per 2 cycles.
REQ-024 DONE: Done=1 for that cycle only -> IDLE.
REQ-025 Start clears ResultCount and Checksum in the same cycle it leaves IDLE; ignored in other states.
REQ-026 Pushes accepted in every state; push in the same cycle as a pop is allowed whenever LoadReady=1; occupancy unchanged.
REQ-027 LoadReady = (occupancy < DEPTH), derived from registered occupancy; push when full is impossible.
REQ-028 Read/write pointers wrap modulo DEPTH; occupancy counter log2(DEPTH)+1 bits.
REQ-029 Push while in CAPTURE with buffer empty is seen by the CAPTURE decision of the following cycle only (registered occupancy), i.e. same-cycle push does not prevent -> DONE.
REQ-030 CPUReady low in RUN holds Instruction stable and stays in RUN indefinitely.

Reset
REQ-031 RESET=0 at a rising edge: state IDLE, pointers/occupancy 0, LastResult 0, ResultCount 0, Checksum 0, Done 0; mid-operation reset discards buffer contents.
REQ-032 Outputs after reset: InstrValid 0, Instruction 0, Busy 0, LoadReady 1.

Configuration
REQ-033 Macro INSTR_ISSUER_CHECKSUM_EN defined: each CAPTURE sets Checksum <= Checksum ^ ALUResult.
REQ-034 Macro undefined: Checksum tied 0, no checksum register synthesised.

Structure
REQ-035 Package instr_issuer_pkg holds state enum, IW/DW defaults, ResultCount width.
REQ-036 Buffer in one sub-module issue_fifo (sync FIFO, push/pop/full/empty/head); FSM and capture in instr_issuer.

Verification
REQ-037 Reset, push 0x1234, 0x5678, Start, CPUReady=1, ALUResult=0x0A then 0x0B -> Instruction 0x1234 then 0x5678, LastResult 0x0B, ResultCount 2, one Done pulse.
REQ-038 Push DEPTH=8 entries -> LoadReady 0 after 8th; one issue -> LoadReady 1 the next cycle; wrap-around order preserved over 12 total pushes.
REQ-039 Start with empty buffer -> Done next cycle, InstrValid never high, ResultCount 0.
REQ-040 CPUReady held 0 for 5 cycles in RUN -> Instruction stable, InstrValid 1, no pop, ResultCount unchanged.
REQ-041 RESET=0 mid-RUN with 3 entries queued -> next cycle IDLE, LoadReady 1, empty buffer, all outputs at reset values.
REQ-042 With INSTR_ISSUER_CHECKSUM_EN, results 0xF0, 0x0F, 0xFF -> Checksum 0x00; without macro Checksum 0 throughout.
